coeff_loader: RTL

Byte-serial coefficient loader for one equalizer band. Sits directly upstream of the band FIR `filter`. It parses a framed byte stream (sync byte, 64 big-endian 16-bit coefficients, optional checksum) and drives the filter's coefficient write port: one `write_enable` strobe per coefficient, then a single `write_done` strobe that commits the new set.

---
 rtl/coeff_loader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/coeff_loader.sv
// rtl/coeff_loader.sv - byte-serial coefficient frame parser driving the band FIR coefficient write port
// Optional trailing XOR checksum check enabled by defining COEFF_CHECKSUM_EN.
module coeff_loader #(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         NUM_COEFFS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_enable,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        write_enable,
  output logic [5:0]  write_address,
  output logic [15:0] coeffs_in,
  output logic        write_done,
  output logic        busy,
  output logic        error
);

  localparam logic [5:0] LAST_ADDR = 6'(NUM_COEFFS - 1);

`ifdef COEFF_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, MSB, LSB, WRITE, CHECK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, MSB, LSB, WRITE, DONE} state_t;
`endif

  state_t     state;
  state_t     next_state;
  logic [7:0] msb_q;
  logic       accept;

  assign accept = s_valid & s_ready & clk_enable;

`ifdef COEFF_CHECKSUM_EN
  logic [7:0] csum;
`endif

  always_comb begin
    next_state   = state;
    s_ready      = 1'b0;
    write_enable = 1'b0;
    write_done   = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (accept && s_data == SYNC_BYTE) next_state = MSB;
      end
      MSB: begin
        s_ready = 1'b1;
        if (accept) next_state = LSB;
      end
      LSB: begin
        s_ready = 1'b1;
        if (accept) next_state = WRITE;
      end
      WRITE: begin
        write_enable = 1'b1;
        if (clk_enable) begin
          if (write_address == LAST_ADDR) begin
`ifdef COEFF_CHECKSUM_EN
            next_state = CHECK;
`else
            next_state = DONE;
`endif
          end else begin
            next_state = MSB;
          end
        end
      end
`ifdef COEFF_CHECKSUM_EN
      CHECK: begin
        s_ready = 1'b1;
        if (accept) next_state = (s_data == csum) ? DONE : IDLE;
      end
`endif
      DONE: begin
        write_done = 1'b1;
        if (clk_enable) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The whole coefficient is loaded at once so coeffs_in is stable for the entire WRITE strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      msb_q         <= 8'h00;
      coeffs_in     <= 16'h0000;
      write_address <= 6'd0;
    end else begin
      state <= next_state;
      if (accept) begin
        case (state)
          IDLE:    if (s_data == SYNC_BYTE) write_address <= 6'd0;
          MSB:     msb_q <= s_data;
          LSB:     coeffs_in <= {msb_q, s_data};
          default: ;
        endcase
      end
      if (clk_enable && state == WRITE) write_address <= write_address + 6'd1;
    end
  end

`ifdef COEFF_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      csum  <= 8'h00;
      error <= 1'b0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (s_data == SYNC_BYTE) begin
            csum  <= 8'h00;
            error <= 1'b0;
          end
        end
        MSB, LSB: csum <= csum ^ s_data;
        CHECK:    if (s_data != csum) error <= 1'b1;
        default:  ;
      endcase
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule
